// File: rtl/aes_key_expand_multi.sv
// aes_key_expand_multi
//   Iterative AES key schedule for 128/192/256-bit keys. The key length is chosen
//   per request. One 32-bit schedule word is produced per clock. The whole schedule
//   is presented as one packed vector for the round datapath.
//
// Ports
//   clk         in   1     rising-edge clock
//   reset_n     in   1     synchronous, active-low reset
//   start       in   1     request pulse, sampled only in IDLE
//   key_len     in   2     00=128, 01=192, 10=256, 11=reserved (sampled with start)
//   key_in      in   256   cipher key, left-aligned (128-bit in [255:128], 192-bit in [255:64])
//   busy        out  1     high from the accept edge until done
//   done        out  1     one-cycle pulse after the last word is written
//   rk_valid    out  1     round_keys/nr valid, from done until the next accepted start
//   key_err     out  1     one-cycle pulse when start arrives with key_len=11 (request dropped)
//   nr          out  4     rounds for the latched key length (10/12/14)
//   round_keys  out  1920  w[i] at [1919-32i -: 32]; unused trailing words read 0
//
// Handshake: a request is accepted on the edge where start=1 is seen in IDLE with a
// valid key_len. busy rises on that edge. start is ignored while busy or in the DONE
// cycle. Completion is the single-cycle done pulse, after which rk_valid stays high.
module aes_key_expand_multi #(
    parameter int NB     = 4,
    parameter int NR_MAX = 14
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [1:0]                      key_len,
    input  logic [255:0]                    key_in,
    output logic                            busy,
    output logic                            done,
    output logic                            rk_valid,
    output logic                            key_err,
    output logic [3:0]                      nr,
    output logic [32*NB*(NR_MAX+1)-1:0]     round_keys
);

    localparam int NW = NB * (NR_MAX + 1);

    // Forward S-box, row-major: byte b lives at bits [8*(255-b) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // ~b equals 255-b for an 8-bit value, giving the byte's offset from the LSB.
        sbox = SBOX[{~b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] w [0:NW-1];
    logic [5:0]  idx;        // index of the word written on the next GEN edge
    logic [2:0]  mod_cnt;    // idx % Nk, kept by a wrap counter
    logic [2:0]  nk_m1;      // Nk-1, wrap point of mod_cnt
    logic [5:0]  nk;
    logic [5:0]  total;
    logic        nk8;
    logic [7:0]  rcon;

    // Request decode, only meaningful with a valid key_len.
    logic [5:0]  new_nk;
    logic [5:0]  new_total;
    logic [3:0]  new_nr;
    logic [7:0]  key_mask;   // which of w[0..7] are loaded from key_in

    always_comb begin
        new_nk    = 6'd0;
        new_total = 6'd0;
        new_nr    = 4'd0;
        key_mask  = 8'h00;
        case (key_len)
            2'b00: begin
                new_nk    = 6'd4;
                new_total = 6'd44;
                new_nr    = 4'd10;
                key_mask  = 8'h0f;
            end
            2'b01: begin
                new_nk    = 6'd6;
                new_total = 6'd52;
                new_nr    = 4'd12;
                key_mask  = 8'h3f;
            end
            2'b10: begin
                new_nk    = 6'd8;
                new_total = 6'd60;
                new_nr    = 4'd14;
                key_mask  = 8'hff;
            end
            default: ;
        endcase
    end

    // Word generation datapath.
    logic [5:0]  prev_idx;
    logic [5:0]  back_idx;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic        at_rot;
    logic        sub_only;
    logic [31:0] sub_in;
    logic [31:0] sub_word;
    logic [31:0] temp;
    logic [31:0] new_word;
    logic [7:0]  rcon_next;

    assign prev_idx  = idx - 6'd1;
    assign back_idx  = idx - nk;
    assign prev_word = w[prev_idx];
    assign back_word = w[back_idx];
    assign at_rot    = (mod_cnt == 3'd0);
    assign sub_only  = nk8 && (mod_cnt == 3'd4);

    // One SubWord shared by the RotWord branch and the 256-bit mid-round branch.
    assign sub_in = at_rot ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign sub_word[8*g +: 8] = sbox(sub_in[8*g +: 8]);
    end

    always_comb begin
        temp = prev_word;
        if (at_rot) begin
            temp = sub_word ^ {rcon, 24'h0};
        end else if (sub_only) begin
            temp = sub_word;
        end
    end

    assign new_word  = back_word ^ temp;
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    for (genvar i = 0; i < NW; i++) begin : g_rk
        assign round_keys[32*(NW-1-i) +: 32] = w[i];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            idx      <= 6'd0;
            mod_cnt  <= 3'd0;
            nk_m1    <= 3'd0;
            nk       <= 6'd0;
            total    <= 6'd0;
            nk8      <= 1'b0;
            rcon     <= 8'h01;
            busy     <= 1'b0;
            done     <= 1'b0;
            rk_valid <= 1'b0;
            key_err  <= 1'b0;
            nr       <= 4'd0;
            for (int i = 0; i < NW; i++) begin
                w[i] <= 32'h0;
            end
        end else begin
            done    <= 1'b0;
            key_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == 2'b11) begin
                            key_err <= 1'b1;
                        end else begin
                            for (int i = 0; i < 8; i++) begin
                                w[i] <= key_mask[i] ? key_in[255-32*i -: 32] : 32'h0;
                            end
                            for (int i = 8; i < NW; i++) begin
                                w[i] <= 32'h0;
                            end
                            idx      <= new_nk;
                            mod_cnt  <= 3'd0;
                            nk_m1    <= new_nk[2:0] - 3'd1;
                            nk       <= new_nk;
                            total    <= new_total;
                            nk8      <= (key_len == 2'b10);
                            nr       <= new_nr;
                            rcon     <= 8'h01;
                            rk_valid <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    w[idx]  <= new_word;
                    idx     <= idx + 6'd1;
                    mod_cnt <= (mod_cnt == nk_m1) ? 3'd0 : mod_cnt + 3'd1;
                    if (at_rot) begin
                        rcon <= rcon_next;
                    end
                    if (idx == total - 6'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    rk_valid <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
